// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports and the single-port RAM side of ram_arbiter.
// The arbiter connects through the master modport.
// The requesters and the RAM connect through the slave modport.
interface ram_arbiter_if #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 4
);
    // Port A
    logic              AReq;
    logic              AReadWrite;
    logic [ADDR_W-1:0] AAddress;
    logic [DATA_W-1:0] ADataIn;
    logic [DATA_W-1:0] ADataOut;
    logic              AAck;

    // Port B
    logic              BReq;
    logic              BReadWrite;
    logic [ADDR_W-1:0] BAddress;
    logic [DATA_W-1:0] BDataIn;
    logic [DATA_W-1:0] BDataOut;
    logic              BAck;

    // RAM side
    logic              MemEnable;
    logic              MemReadWrite;
    logic [ADDR_W-1:0] MemAddress;
    logic [DATA_W-1:0] MemDataIn;
    logic [DATA_W-1:0] MemDataOut;

    logic              Busy;

    modport master (
        input  AReq, AReadWrite, AAddress, ADataIn,
        output ADataOut, AAck,
        input  BReq, BReadWrite, BAddress, BDataIn,
        output BDataOut, BAck,
        output MemEnable, MemReadWrite, MemAddress, MemDataIn,
        input  MemDataOut,
        output Busy
    );

    modport slave (
        output AReq, AReadWrite, AAddress, ADataIn,
        input  ADataOut, AAck,
        output BReq, BReadWrite, BAddress, BDataIn,
        input  BDataOut, BAck,
        input  MemEnable, MemReadWrite, MemAddress, MemDataIn,
        output MemDataOut,
        input  Busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// Each transaction runs IDLE -> ACCESS -> (CAPTURE for reads) -> DONE.
// All RAM-side outputs, acks, read data and Busy come straight from flops.
module ram_arbiter #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 4
) (
    input  logic          Clock,
    input  logic          nReset,
    ram_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAccess  = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic              win_b_q, win_b_d;    // port being served, 1 = B
    logic              last_b_q, last_b_d;  // last completed grant, 1 = B (so A wins the next tie)
    logic              mem_en_q, mem_en_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] a_dout_q, a_dout_d;
    logic [DATA_W-1:0] b_dout_q, b_dout_d;

    logic              grant_b;
    logic              enter_done;

    // Next-state and registered-output logic for the transaction FSM.
    always_comb begin
        state_d    = state_q;
        win_b_d    = win_b_q;
        last_b_d   = last_b_q;
        mem_en_d   = mem_en_q;
        mem_rw_d   = mem_rw_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        busy_d     = busy_q;
        a_dout_d   = a_dout_q;
        b_dout_d   = b_dout_q;
        grant_b    = 1'b0;
        enter_done = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A lone requester wins; on a tie the port not granted last wins.
                grant_b = bus.BReq & (~bus.AReq | ~last_b_q);
                if (bus.AReq | bus.BReq) begin
                    state_d    = StAccess;
                    win_b_d    = grant_b;
                    mem_en_d   = 1'b1;
                    mem_rw_d   = grant_b ? bus.BReadWrite : bus.AReadWrite;
                    mem_addr_d = grant_b ? bus.BAddress   : bus.AAddress;
                    mem_din_d  = grant_b ? bus.BDataIn    : bus.ADataIn;
                end
            end
            StAccess: begin
                if (mem_rw_q) begin
                    state_d = StCapture;
                end else begin
                    enter_done = 1'b1;
                end
            end
            StCapture: begin
                // RAM data became valid at the edge that left ACCESS.
                enter_done = 1'b1;
                if (win_b_q) begin
                    b_dout_d = bus.MemDataOut;
                end else begin
                    a_dout_d = bus.MemDataOut;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // RAM is released, the winner is acked and the pointer moves on entry to DONE.
        if (enter_done) begin
            state_d  = StDone;
            mem_en_d = 1'b0;
            last_b_d = win_b_q;
            a_ack_d  = ~win_b_q;
            b_ack_d  = win_b_q;
        end

        busy_d = (state_d != StIdle);
    end

    // FSM state and arbitration pointer registers.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q  <= StIdle;
            win_b_q  <= 1'b0;
            last_b_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            win_b_q  <= win_b_d;
            last_b_q <= last_b_d;
        end
    end

    // Registered RAM controls, acks, Busy and per-port read data.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            mem_en_q   <= 1'b0;
            mem_rw_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            busy_q     <= 1'b0;
            a_dout_q   <= '0;
            b_dout_q   <= '0;
        end else begin
            mem_en_q   <= mem_en_d;
            mem_rw_q   <= mem_rw_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            busy_q     <= busy_d;
            a_dout_q   <= a_dout_d;
            b_dout_q   <= b_dout_d;
        end
    end

    assign bus.MemEnable    = mem_en_q;
    assign bus.MemReadWrite = mem_rw_q;
    assign bus.MemAddress   = mem_addr_q;
    assign bus.MemDataIn    = mem_din_q;
    assign bus.AAck         = a_ack_q;
    assign bus.BAck         = b_ack_q;
    assign bus.Busy         = busy_q;
    assign bus.ADataOut     = a_dout_q;
    assign bus.BDataOut     = b_dout_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a synchronous RAM model sits on the memory side,
// and a transaction-level reference (memory array, round-robin preference bit, expected
// read-data registers, per-transaction latency arithmetic) predicts every result.
module tb_ram_arbiter;
    localparam int unsigned DW = 256;
    localparam int unsigned AW = 4;

    logic Clock;
    logic nReset;

    ram_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ram_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus)
    );

    int n_checks;
    int n_pass;

    // Reference model state
    bit          favour_a;
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] exp_aout;
    logic [DW-1:0] exp_bout;

    // RAM model: read data valid one edge after an enabled read; garbage when disabled
    logic [DW-1:0] ram [16];
    logic [DW-1:0] ram_rd;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (bus.MemEnable) begin
            if (bus.MemReadWrite) ram_rd <= ram[bus.MemAddress];
            else                  ram[bus.MemAddress] <= bus.MemDataIn;
        end
    end

    assign bus.MemDataOut = bus.MemEnable ? ram_rd : {8{32'hDEAD_BEEF}};

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // One or two simultaneous requests; latency counts the Req-sampling IDLE cycle as 1.
    task automatic run_pair(input bit a_on, input bit a_rd, input logic [AW-1:0] a_addr,
                            input logic [DW-1:0] a_din,
                            input bit b_on, input bit b_rd, input logic [AW-1:0] b_addr,
                            input logic [DW-1:0] b_din);
        bit first_a, served_a, a_done, b_done, bus_ok, overlap, extra, pa;
        int l_a, l_b, a_cyc, b_cyc, en_cnt, en_exp;
        first_a = (a_on && b_on) ? favour_a : a_on;
        l_a     = a_rd ? 4 : 3;
        l_b     = b_rd ? 4 : 3;
        en_exp  = (a_on ? (a_rd ? 2 : 1) : 0) + (b_on ? (b_rd ? 2 : 1) : 0);
        a_done  = !a_on;
        b_done  = !b_on;
        bus_ok  = 1'b1;
        overlap = 1'b0;
        extra   = 1'b0;
        a_cyc   = 0;
        b_cyc   = 0;
        en_cnt  = 0;

        bus.AReq = a_on; bus.AReadWrite = a_rd; bus.AAddress = a_addr; bus.ADataIn = a_din;
        bus.BReq = b_on; bus.BReadWrite = b_rd; bus.BAddress = b_addr; bus.BDataIn = b_din;

        for (int k = 1; k <= 30 && !(a_done && b_done); k++) begin
            @(negedge Clock);
            served_a = first_a ? !a_done : b_done;
            if (bus.MemEnable) begin
                en_cnt++;
                if (served_a) begin
                    bus_ok &= (bus.MemAddress == a_addr) && (bus.MemReadWrite == a_rd) &&
                              (bus.MemDataIn == a_din);
                    bus.AAddress   = bus.AAddress + 4'd4;
                    bus.AReadWrite = ~bus.AReadWrite;
                    bus.ADataIn    = ~bus.ADataIn;
                end else begin
                    bus_ok &= (bus.MemAddress == b_addr) && (bus.MemReadWrite == b_rd) &&
                              (bus.MemDataIn == b_din);
                    bus.BAddress   = bus.BAddress + 4'd4;
                    bus.BReadWrite = ~bus.BReadWrite;
                    bus.BDataIn    = ~bus.BDataIn;
                end
            end
            if (bus.AAck && bus.BAck) overlap = 1'b1;
            if (bus.AAck) begin
                if (a_done) extra = 1'b1;
                else begin a_done = 1'b1; a_cyc = k + 1; bus.AReq = 1'b0; end
            end
            if (bus.BAck) begin
                if (b_done) extra = 1'b1;
                else begin b_done = 1'b1; b_cyc = k + 1; bus.BReq = 1'b0; end
            end
        end
        bus.AReq = 1'b0;
        bus.BReq = 1'b0;

        if (a_on) check("a_ack_cycle", 256'(a_cyc), 256'(first_a ? l_a : l_b + l_a));
        if (b_on) check("b_ack_cycle", 256'(b_cyc), 256'(first_a ? l_a + l_b : l_b));
        check("mem_bus_latched", 256'(bus_ok), 256'(1));
        check("mem_en_cycles", 256'(en_cnt), 256'(en_exp));
        check("ack_overlap", 256'(overlap), 256'(0));
        check("extra_ack", 256'(extra), 256'(0));

        for (int s = 0; s < 2; s++) begin
            pa = (s == 0) ? first_a : !first_a;
            if (pa && a_on) begin
                if (a_rd) exp_aout = ref_mem[a_addr];
                else      ref_mem[a_addr] = a_din;
                favour_a = 1'b0;
            end else if (!pa && b_on) begin
                if (b_rd) exp_bout = ref_mem[b_addr];
                else      ref_mem[b_addr] = b_din;
                favour_a = 1'b1;
            end
        end
        check("a_dataout", bus.ADataOut, exp_aout);
        check("b_dataout", bus.BDataOut, exp_bout);

        @(negedge Clock);
        check("busy_after_txn", 256'(bus.Busy), 256'(0));
    endtask

    // Start an A transaction and pull reset after at_k cycles (1 = ACCESS, 2 = CAPTURE).
    task automatic abort_txn(input bit rd, input logic [AW-1:0] addr, input logic [DW-1:0] din,
                             input int at_k);
        bit ack_seen;
        ack_seen = 1'b0;
        bus.AReq = 1'b1; bus.AReadWrite = rd; bus.AAddress = addr; bus.ADataIn = din;
        repeat (at_k) begin
            @(negedge Clock);
            if (bus.AAck || bus.BAck) ack_seen = 1'b1;
        end
        nReset = 1'b0;
        #1;
        check("rst_ctrl", 256'({bus.MemEnable, bus.MemReadWrite, bus.AAck, bus.BAck, bus.Busy}),
              256'(0));
        check("rst_mem_addr", 256'(bus.MemAddress), 256'(0));
        check("rst_mem_din", bus.MemDataIn, '0);
        check("rst_a_dataout", bus.ADataOut, '0);
        check("rst_b_dataout", bus.BDataOut, '0);
        bus.AReq = 1'b0;
        repeat (2) begin
            @(negedge Clock);
            if (bus.AAck || bus.BAck) ack_seen = 1'b1;
        end
        nReset   = 1'b1;
        favour_a = 1'b1;
        exp_aout = '0;
        exp_bout = '0;
        repeat (3) begin
            @(negedge Clock);
            if (bus.AAck || bus.BAck) ack_seen = 1'b1;
        end
        check("abort_no_ack", 256'(ack_seen), 256'(0));
    endtask

    initial begin
        int unsigned sel;
        bit idle_ok;
        logic [AW-1:0] snap_addr;
        logic [DW-1:0] snap_din;
        logic snap_rw;

        n_checks = 0;
        n_pass   = 0;
        favour_a = 1'b1;
        exp_aout = '0;
        exp_bout = '0;
        bus.AReq = 1'b0; bus.AReadWrite = 1'b0; bus.AAddress = '0; bus.ADataIn = '0;
        bus.BReq = 1'b0; bus.BReadWrite = 1'b0; bus.BAddress = '0; bus.BDataIn = '0;
        nReset = 1'b1;
        #1 nReset = 1'b0;
        #2;
        check("reset_ctrl", 256'({bus.MemEnable, bus.MemReadWrite, bus.AAck, bus.BAck, bus.Busy}),
              256'(0));
        check("reset_mem_addr", 256'(bus.MemAddress), 256'(0));
        check("reset_mem_din", bus.MemDataIn, '0);
        check("reset_dataout", {bus.ADataOut[127:0], bus.BDataOut[127:0]}, '0);
        repeat (2) @(negedge Clock);
        nReset = 1'b1;
        @(negedge Clock);

        // Simultaneous writes over all 16 addresses: A first after reset, then strict alternation
        for (int i = 0; i < 8; i++)
            run_pair(1'b1, 1'b0, 4'(2 * i), rand256(), 1'b1, 1'b0, 4'(2 * i + 1), rand256());

        // Write-then-read on port A alone
        run_pair(1'b1, 1'b0, 4'd3, 256'h1234, 1'b0, 1'b0, 4'd0, '0);
        run_pair(1'b1, 1'b1, 4'd3, rand256(), 1'b0, 1'b0, 4'd0, '0);
        check("a_read_1234", bus.ADataOut, 256'h1234);

        // Address 5 moved to 9 during ACCESS must not leak onto MemAddress
        run_pair(1'b1, 1'b0, 4'd5, rand256(), 1'b0, 1'b0, 4'd0, '0);
        run_pair(1'b1, 1'b1, 4'd15, '0, 1'b1, 1'b1, 4'd5, '0);

        // Randomised mixes of single and simultaneous requests
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(1, 3);
            run_pair(sel[0], 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand256(),
                     sel[1], 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand256());
        end

        // 20 quiet cycles: RAM off, not busy, fields and read data held
        idle_ok   = 1'b1;
        snap_addr = bus.MemAddress;
        snap_din  = bus.MemDataIn;
        snap_rw   = bus.MemReadWrite;
        repeat (20) begin
            @(negedge Clock);
            if (bus.MemEnable || bus.Busy || bus.AAck || bus.BAck) idle_ok = 1'b0;
            if (bus.MemAddress != snap_addr || bus.MemDataIn != snap_din ||
                bus.MemReadWrite != snap_rw) idle_ok = 1'b0;
        end
        check("idle_quiet", 256'(idle_ok), 256'(1));
        check("idle_a_dataout", bus.ADataOut, exp_aout);
        check("idle_b_dataout", bus.BDataOut, exp_bout);

        // Reset during a write's ACCESS: the write must not land
        abort_txn(1'b0, 4'd11, rand256(), 1);
        run_pair(1'b1, 1'b1, 4'd11, '0, 1'b1, 1'b1, 4'd12, '0);
        run_pair(1'b1, 1'b1, 4'd3, '0, 1'b1, 1'b1, 4'd4, '0);

        // Reset during a read's CAPTURE, then reissue
        abort_txn(1'b1, 4'd3, '0, 2);
        run_pair(1'b1, 1'b1, 4'd3, '0, 1'b0, 1'b0, 4'd0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
